// File: rtl/barrel_sched_pkg.sv
// Shared types and default sizing for the barrel spawn scheduler.
package barrel_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        HOLD = 2'd2,
        GAP  = 2'd3
    } sched_state_t;

    localparam int DEF_NUM_SLOTS  = 16;
    localparam int DEF_START_HOLD = 2;
    localparam int DEF_MIN_GAP    = 8;

endpackage

// File: rtl/barrel_spawn_sched_slot_pick.sv
// Free-slot picker: scans the free mask starting at a rotation offset and
// returns a one-hot grant for the first free slot found, wrapping at N-1.
module slot_pick #(
    parameter int N  = 16,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_free,
    input  logic [IW-1:0] i_rot,
    output logic [N-1:0]  o_grant,
    output logic          o_valid
);

    logic [IW-1:0] w_pos;

    always_comb begin
        o_grant = '0;
        o_valid = 1'b0;
        w_pos   = '0;
        for (int k = 0; k < N; k++) begin
            w_pos = IW'((int'(i_rot) + k) % N);
            if (!o_valid && i_free[w_pos]) begin
                o_valid        = 1'b1;
                o_grant[w_pos] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/barrel_spawn_sched.sv
// Allocates barrel slots to Kong drop events with a held start window and
// launch spacing. Define BARREL_SCHED_RR_ALLOC_EN for round-robin allocation.
module barrel_spawn_sched
    import barrel_sched_pkg::*;
#(
    parameter int NUM_SLOTS  = DEF_NUM_SLOTS,
    parameter int START_HOLD = DEF_START_HOLD,
    parameter int MIN_GAP    = DEF_MIN_GAP,
    parameter int CW         = $clog2(NUM_SLOTS + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tick,
    input  logic                 run,
    input  logic                 drop_req,
    input  logic [NUM_SLOTS-1:0] slot_done,
    output logic [NUM_SLOTS-1:0] start,
    output logic [NUM_SLOTS-1:0] busy,
    output logic [CW-1:0]        active_count,
    output logic                 full,
    output logic                 drop_ack,
    output logic                 drop_lost
);

    localparam int IW   = $clog2(NUM_SLOTS);
    localparam int MAXC = (START_HOLD > MIN_GAP) ? START_HOLD : MIN_GAP;
    localparam int TW   = $clog2(MAXC + 1);

    sched_state_t         r_state;
    logic [NUM_SLOTS-1:0] r_start;
    logic [NUM_SLOTS-1:0] r_busy;
    logic [CW-1:0]        r_count;
    logic                 r_full;
    logic                 r_drop_ack;
    logic                 r_drop_lost;
    logic                 r_pending;
    logic [TW-1:0]        r_cnt;

    logic [NUM_SLOTS-1:0] w_grant;
    logic                 w_pick_valid;
    logic [IW-1:0]        w_rot;
    logic                 w_launch;
    logic                 w_hold_done;
    logic [NUM_SLOTS-1:0] w_busy_nxt;
    logic [NUM_SLOTS-1:0] w_start_nxt;
    logic [CW-1:0]        w_count_nxt;

    slot_pick #(
        .N  (NUM_SLOTS),
        .IW (IW)
    ) u_pick (
        .i_free  (~r_busy),
        .i_rot   (w_rot),
        .o_grant (w_grant),
        .o_valid (w_pick_valid)
    );

    // Selection looks only at registered busy, so a slot retired this cycle
    // cannot be granted until the next one.
    assign w_launch    = r_pending && w_pick_valid && ((r_state == IDLE) || (r_state == PEND));
    assign w_hold_done = (r_state == HOLD) && tick && (r_cnt <= TW'(1));
    assign w_busy_nxt  = (r_busy & ~slot_done) | (w_launch ? w_grant : '0);
    assign w_start_nxt = w_launch    ? w_grant :
                         w_hold_done ? '0      : (r_start & ~slot_done);

    always_comb begin
        w_count_nxt = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            w_count_nxt = w_count_nxt + CW'(w_busy_nxt[i]);
        end
    end

`ifdef BARREL_SCHED_RR_ALLOC_EN
    logic [IW-1:0] r_ptr;
    logic [IW-1:0] w_ptr_nxt;

    always_comb begin
        w_ptr_nxt = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (w_grant[i]) begin
                w_ptr_nxt = (i == NUM_SLOTS - 1) ? '0 : IW'(i + 1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (!run) begin
            r_ptr <= '0;
        end else if (w_launch) begin
            r_ptr <= w_ptr_nxt;
        end
    end

    assign w_rot = r_ptr;
`else
    assign w_rot = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_start     <= '0;
            r_busy      <= '0;
            r_count     <= '0;
            r_full      <= 1'b0;
            r_drop_ack  <= 1'b0;
            r_drop_lost <= 1'b0;
            r_pending   <= 1'b0;
            r_cnt       <= '0;
        end else if (!run) begin
            r_state     <= IDLE;
            r_start     <= '0;
            r_busy      <= '0;
            r_count     <= '0;
            r_full      <= 1'b0;
            r_drop_ack  <= 1'b0;
            r_drop_lost <= 1'b0;
            r_pending   <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_busy      <= w_busy_nxt;
            r_start     <= w_start_nxt;
            r_count     <= w_count_nxt;
            r_full      <= &w_busy_nxt;
            r_drop_ack  <= w_launch;
            r_drop_lost <= drop_req && r_pending;

            if (w_launch) begin
                r_pending <= 1'b0;
            end else if (drop_req) begin
                r_pending <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (r_pending) begin
                        if (w_launch) begin
                            r_state <= HOLD;
                            r_cnt   <= TW'(START_HOLD);
                        end else begin
                            r_state <= PEND;
                        end
                    end
                end
                PEND: begin
                    if (w_launch) begin
                        r_state <= HOLD;
                        r_cnt   <= TW'(START_HOLD);
                    end
                end
                HOLD: begin
                    if (tick) begin
                        if (r_cnt <= TW'(1)) begin
                            r_cnt   <= TW'(MIN_GAP);
                            r_state <= (MIN_GAP > 0) ? GAP : (r_pending ? PEND : IDLE);
                        end else begin
                            r_cnt <= r_cnt - TW'(1);
                        end
                    end
                end
                GAP: begin
                    if (tick) begin
                        if (r_cnt <= TW'(1)) begin
                            r_cnt   <= '0;
                            r_state <= r_pending ? PEND : IDLE;
                        end else begin
                            r_cnt <= r_cnt - TW'(1);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign start        = r_start;
    assign busy         = r_busy;
    assign active_count = r_count;
    assign full         = r_full;
    assign drop_ack     = r_drop_ack;
    assign drop_lost    = r_drop_lost;

endmodule

// File: tb/tb_barrel_spawn_sched.sv
// Self-checking bench for barrel_spawn_sched; expected launch slots are queued
// when a drop is requested and compared when drop_ack appears.
module tb_barrel_spawn_sched;
    import barrel_sched_pkg::*;

    localparam int N  = 16;
    localparam int CW = $clog2(N + 1);

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          tick      = 1'b0;
    logic          run       = 1'b0;
    logic          drop_req  = 1'b0;
    logic [N-1:0]  slot_done = '0;
    logic [N-1:0]  start;
    logic [N-1:0]  busy;
    logic [CW-1:0] active_count;
    logic          full;
    logic          drop_ack;
    logic          drop_lost;

    int checks = 0;
    int errors = 0;
    int expQ[$];

    barrel_spawn_sched #(
        .NUM_SLOTS  (N),
        .START_HOLD (2),
        .MIN_GAP    (8),
        .CW         (CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tick         (tick),
        .run          (run),
        .drop_req     (drop_req),
        .slot_done    (slot_done),
        .start        (start),
        .busy         (busy),
        .active_count (active_count),
        .full         (full),
        .drop_ack     (drop_ack),
        .drop_lost    (drop_lost)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_ticks(input int n);
        for (int t = 0; t < n; t++) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
            step();
        end
    endtask

    task automatic flush();
        run = 1'b0;
        step();
        run = 1'b1;
    endtask

    task automatic retire(input int slot);
        slot_done[slot] = 1'b1;
        step();
        slot_done = '0;
    endtask

    // Issue one drop request and wait (bounded) for drop_ack; optionally tick
    // through HOLD+GAP so the scheduler is idle again afterwards.
    task automatic launch_one(input bit withTicks, output logic [N-1:0] obs, output bit got);
        drop_req = 1'b1;
        step();
        drop_req = 1'b0;
        got = 1'b0;
        obs = '0;
        for (int c = 0; c < 40 && !got; c++) begin
            step();
            if (drop_ack === 1'b1) begin
                got = 1'b1;
                obs = start;
            end
        end
        if (withTicks) run_ticks(10);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        run   = 1'b0;
        step();
        step();
        checks++; if (start !== '0) begin errors++; $display("[TB] FAIL reset_start got %h expected 0", start); end
        checks++; if (busy !== '0) begin errors++; $display("[TB] FAIL reset_busy got %h expected 0", busy); end
        checks++; if (active_count !== '0) begin errors++; $display("[TB] FAIL reset_count got %0d expected 0", active_count); end
        checks++; if ({full, drop_ack, drop_lost} !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags got %b expected 000", {full, drop_ack, drop_lost}); end
        checks++; if (dut.r_state !== IDLE) begin errors++; $display("[TB] FAIL reset_state got %0d expected IDLE", dut.r_state); end
        rst_n = 1'b1;
        run   = 1'b1;
        step();
    endtask

    task automatic test_single_launch();
        logic [N-1:0] obs;
        bit got;
        int expSlot;
        expQ.push_back(0);
        launch_one(1'b0, obs, got);
        expSlot = expQ.pop_front();
        checks++; if (!got || obs !== (N'(1) << expSlot)) begin errors++; $display("[TB] FAIL single_start got %h (ack %0d) expected %h", obs, got, N'(1) << expSlot); end
        checks++; if (busy !== 16'h0001 || active_count !== CW'(1)) begin errors++; $display("[TB] FAIL single_busy got %h/%0d expected 0001/1", busy, active_count); end
        step();
        checks++; if (drop_ack !== 1'b0) begin errors++; $display("[TB] FAIL single_ack_width got %b expected 0", drop_ack); end
        run_ticks(1);
        checks++; if (start !== 16'h0001) begin errors++; $display("[TB] FAIL single_hold_1tick got %h expected 0001", start); end
        tick = 1'b1;
        step();
        tick = 1'b0;
        checks++; if (start !== '0) begin errors++; $display("[TB] FAIL single_hold_end got %h expected 0", start); end
        step();
        run_ticks(8);
        checks++; if (dut.r_state !== IDLE || busy !== 16'h0001) begin errors++; $display("[TB] FAIL single_idle state %0d busy %h expected IDLE/0001", dut.r_state, busy); end
    endtask

    task automatic test_spacing();
        int acks = 0;
        int losts = 0;
        int tickCount = 0;
        int secondAt = -1;
        int expSlot;
        flush();
        expQ.push_back(0);
        for (int c = 0; c < 80 && acks < 2; c++) begin
            drop_req = (c < 3);
            if (c == 3) expQ.push_back(1);
            tick = (c >= 3) && (((c - 3) % 2) == 0);
            if (tick) tickCount++;
            step();
            if (drop_lost === 1'b1) losts++;
            if (drop_ack === 1'b1) begin
                acks++;
                expSlot = expQ.pop_front();
                checks++; if (start !== (N'(1) << expSlot)) begin errors++; $display("[TB] FAIL spacing_slot got %h expected %h", start, N'(1) << expSlot); end
                if (acks == 2) secondAt = tickCount;
            end
        end
        drop_req = 1'b0;
        tick = 1'b0;
        checks++; if (acks != 2) begin errors++; $display("[TB] FAIL spacing_acks got %0d expected 2", acks); end
        checks++; if (losts != 1) begin errors++; $display("[TB] FAIL spacing_lost got %0d expected 1", losts); end
        checks++; if (secondAt != 10) begin errors++; $display("[TB] FAIL spacing_ticks got %0d expected 10", secondAt); end
    endtask

    task automatic test_full();
        logic [N-1:0] obs;
        bit got;
        bit anyAck = 1'b0;
        int expSlot;
        flush();
        for (int k = 0; k < N; k++) begin
            expQ.push_back(k);
            launch_one(1'b1, obs, got);
            expSlot = expQ.pop_front();
            checks++; if (!got || obs !== (N'(1) << expSlot)) begin errors++; $display("[TB] FAIL fill_slot got %h (ack %0d) expected %h", obs, got, N'(1) << expSlot); end
        end
        checks++; if (full !== 1'b1 || active_count !== CW'(N)) begin errors++; $display("[TB] FAIL full_flag got %b/%0d expected 1/16", full, active_count); end
        drop_req = 1'b1;
        step();
        drop_req = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            if (drop_ack === 1'b1 || start !== '0) anyAck = 1'b1;
        end
        checks++; if (dut.r_state !== PEND || anyAck) begin errors++; $display("[TB] FAIL full_pend state %0d launched %0d expected PEND/0", dut.r_state, anyAck); end
        expQ.push_back(5);
        retire(5);
        checks++; if (drop_ack !== 1'b0 || busy[5] !== 1'b0 || full !== 1'b0) begin errors++; $display("[TB] FAIL full_retire ack %b busy5 %b full %b expected 0/0/0", drop_ack, busy[5], full); end
        step();
        expSlot = expQ.pop_front();
        checks++; if (drop_ack !== 1'b1 || start !== (N'(1) << expSlot)) begin errors++; $display("[TB] FAIL full_relaunch ack %b start %h expected 1/%h", drop_ack, start, N'(1) << expSlot); end
        run_ticks(10);
    endtask

    task automatic test_alloc();
        logic [N-1:0] obs;
        bit got;
        int expSlot;
        flush();
        for (int k = 0; k < 8; k++) begin
            expQ.push_back(k);
            launch_one(1'b1, obs, got);
            expSlot = expQ.pop_front();
            checks++; if (!got || obs !== (N'(1) << expSlot)) begin errors++; $display("[TB] FAIL alloc_fill got %h expected %h", obs, N'(1) << expSlot); end
        end
        retire(3);
        checks++; if (busy !== 16'h00F7) begin errors++; $display("[TB] FAIL alloc_retire got %h expected 00f7", busy); end
`ifdef BARREL_SCHED_RR_ALLOC_EN
        expQ.push_back(8);
        for (int k = 9; k < N; k++) expQ.push_back(k);
        expQ.push_back(3);
        expQ.push_back(12);
        expQ.push_back(3);
        for (int k = 0; k < 10; k++) begin
            if (k == 8) retire(12);
            if (k == 9) retire(3);
            launch_one(1'b1, obs, got);
            expSlot = expQ.pop_front();
            checks++; if (!got || obs !== (N'(1) << expSlot)) begin errors++; $display("[TB] FAIL alloc_rr got %h expected %h", obs, N'(1) << expSlot); end
        end
`else
        expQ.push_back(3);
        launch_one(1'b1, obs, got);
        expSlot = expQ.pop_front();
        checks++; if (!got || obs !== (N'(1) << expSlot)) begin errors++; $display("[TB] FAIL alloc_lowest got %h expected %h", obs, N'(1) << expSlot); end
`endif
    endtask

    task automatic test_simultaneous();
        logic [N-1:0] obs;
        bit got;
        int expSlot;
        flush();
        expQ.push_back(0);
        launch_one(1'b1, obs, got);
        expSlot = expQ.pop_front();
        checks++; if (!got || obs !== (N'(1) << expSlot)) begin errors++; $display("[TB] FAIL simul_first got %h expected %h", obs, N'(1) << expSlot); end
        drop_req = 1'b1;
        step();
        drop_req = 1'b0;
        slot_done[0] = 1'b1;
        expQ.push_back(1);
        step();
        slot_done = '0;
        expSlot = expQ.pop_front();
        checks++; if (drop_ack !== 1'b1 || start !== (N'(1) << expSlot)) begin errors++; $display("[TB] FAIL simul_grant ack %b start %h expected 1/%h", drop_ack, start, N'(1) << expSlot); end
        checks++; if (busy !== 16'h0002 || active_count !== CW'(1)) begin errors++; $display("[TB] FAIL simul_busy got %h/%0d expected 0002/1", busy, active_count); end
        run_ticks(10);
        retire(7);
        checks++; if (busy !== 16'h0002) begin errors++; $display("[TB] FAIL simul_idle_done got %h expected 0002", busy); end
    endtask

    task automatic test_flush();
        logic [N-1:0] obs;
        bit got;
        bit anyAck = 1'b0;
        int expSlot;
        flush();
        for (int k = 0; k < 6; k++) begin
            expQ.push_back(k);
            launch_one(k < 5, obs, got);
            expSlot = expQ.pop_front();
            checks++; if (!got || obs !== (N'(1) << expSlot)) begin errors++; $display("[TB] FAIL flush_fill got %h expected %h", obs, N'(1) << expSlot); end
        end
        run_ticks(1);
        checks++; if (dut.r_state !== HOLD || start !== 16'h0020 || active_count !== CW'(6)) begin errors++; $display("[TB] FAIL flush_pre state %0d start %h count %0d expected HOLD/0020/6", dut.r_state, start, active_count); end
        run = 1'b0;
        step();
        checks++; if (start !== '0 || busy !== '0 || active_count !== '0) begin errors++; $display("[TB] FAIL flush_outputs start %h busy %h count %0d expected 0", start, busy, active_count); end
        checks++; if ({full, drop_ack, drop_lost} !== 3'b000 || dut.r_state !== IDLE) begin errors++; $display("[TB] FAIL flush_state flags %b state %0d expected 000/IDLE", {full, drop_ack, drop_lost}, dut.r_state); end
        drop_req = 1'b1;
        step();
        drop_req = 1'b0;
        run = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            if (drop_ack === 1'b1 || busy !== '0) anyAck = 1'b1;
        end
        checks++; if (anyAck) begin errors++; $display("[TB] FAIL flush_ignored_req got launch 1 expected 0"); end
        expQ.push_back(0);
        launch_one(1'b0, obs, got);
        expSlot = expQ.pop_front();
        checks++; if (!got || obs !== (N'(1) << expSlot)) begin errors++; $display("[TB] FAIL flush_relaunch got %h expected %h", obs, N'(1) << expSlot); end
        run_ticks(3);
        checks++; if (dut.r_state !== GAP) begin errors++; $display("[TB] FAIL flush_gap got %0d expected GAP", dut.r_state); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== '0 || start !== '0 || active_count !== '0) begin errors++; $display("[TB] FAIL async_reset busy %h start %h count %0d expected 0", busy, start, active_count); end
        checks++; if (dut.r_state !== IDLE) begin errors++; $display("[TB] FAIL async_state got %0d expected IDLE", dut.r_state); end
        #2;
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired before completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_single_launch();
        test_spacing();
        test_full();
        test_alloc();
        test_simultaneous();
        test_flush();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/barrel_spawn_sched.md
# barrel_spawn_sched

Allocates the fixed pool of barrel instances to Kong's drop events. It sits between the kong drop output and the per-slot barrel `start`/`over` inputs, and tracks which slots are in flight. It launches a free slot with a held start window and enforces a minimum spacing between launches. It retires slots on completion, so a barrel still rolling is never restarted by a wrapped index.

## Interface
- `NUM_SLOTS`, 16: number of barrel instances managed (2..32).
- `START_HOLD`, 2: ticks `start[i]` stays asserted after launch (≥1).
- `MIN_GAP`, 8: ticks after the hold window before the next launch (0 = none).
- `CW`, $clog2(NUM_SLOTS+1): width of `active_count`.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `tick` in 1: one-`clk` enable pulse at barrel game-tick rate.
- `run` in 1: game running; low flushes all state.
- `drop_req` in 1: one-`clk` pulse from kong drop detect.
- `slot_done` in NUM_SLOTS: barrel i finished (reached bin or collided out); level or pulse.
- `start` out NUM_SLOTS: one-hot launch enable to barrel i.
- `busy` out NUM_SLOTS: slot occupancy.
- `active_count` out CW: popcount of `busy`.
- `full` out 1: `&busy`.
- `drop_ack` out 1: one-`clk` pulse on launch.
- `drop_lost` out 1: one-`clk` pulse when a request is discarded.

## Operation
- FSM states: IDLE, PEND, HOLD, GAP.
- Reset values (async, `rst_n` low): state IDLE, `start`=0, `busy`=0, `active_count`=0, `full`=0, `drop_ack`=0, `drop_lost`=0, pending=0, tick counter=0, round-robin pointer=0.
- Pending flag (one deep):
  - `drop_req` sets it.
  - A launch clears it.
  - `drop_req` while pending=1 pulses `drop_lost` next cycle; the request is discarded.
- IDLE: pending=1 → PEND.
- PEND, launch condition: free mask (`~busy`) is nonzero.
  - Pick slot i, then set `busy[i]` and `start[i]`, pulse `drop_ack`, clear pending, load tick counter with START_HOLD, and go to HOLD.
  - With free mask zero, stay in PEND and keep pending; `full`=1.
- HOLD: decrement on `tick`. At 0, clear `start`.
  - MIN_GAP>0: load MIN_GAP → GAP.
  - MIN_GAP=0: → PEND if pending, else IDLE.
- GAP: decrement on `tick`. At 0 → PEND if pending, else IDLE.
- Retire: `slot_done[i]` & `busy[i]` clears `busy[i]`. `slot_done` on a non-busy slot is ignored.
- Retire has priority over launch for the same slot. A slot freed in cycle n is selectable from cycle n+1 only, because selection uses the registered `busy`.
- `slot_done[i]` during HOLD of slot i clears `busy[i]` and `start[i]`; the FSM still completes HOLD timing.
- `run`=0: synchronous flush.
  - All outputs and state return to reset values on the next edge.
  - `drop_req` is ignored while `run`=0.
- `active_count` and `full` are registered from next-state `busy`, so they are consistent with `busy` in the same cycle.

## Timing
- Launch latency: `drop_req` at edge n → pending at n+1 → `start[i]`, `busy[i]`, `drop_ack` high at n+2 (IDLE, free slot).
- `start` width is START_HOLD ticks. It falls on the cycle after the START_HOLD-th `tick` following launch. A `tick` coincident with the launch edge is not counted.
- Minimum launch spacing is (START_HOLD+MIN_GAP) ticks + 1 `clk`.
- Retire latency: `slot_done[i]` sampled at edge n → `busy[i]`=0 at n+1.

## Configuration
- Macro: `BARREL_SCHED_RR_ALLOC_EN`.
- Defined: round-robin allocation. The first free slot at or above the pointer is chosen, wrapping NUM_SLOTS-1 → 0. On launch the pointer becomes i+1 mod NUM_SLOTS.
- Undefined: the lowest-index free slot is chosen. The pointer register is not built.

## Structure
- Package `barrel_sched_pkg`: FSM state enum (IDLE, PEND, HOLD, GAP), default NUM_SLOTS/START_HOLD/MIN_GAP constants.
- Sub-module `slot_pick`: combinational free-mask → one-hot grant plus valid. Its rotation input is tied to 0 when the macro is off.
- Counter, pending flag and FSM stay in `barrel_spawn_sched`.

## Test plan
- Reset / single launch: reset, `run`=1, one `drop_req`. Expect `start`=16'h0001 two cycles later and `drop_ack` pulse; `start` clears after 2 ticks. Expect `busy`=16'h0001, `active_count`=1.
- Spacing: three `drop_req` 1 `clk` apart with START_HOLD=2, MIN_GAP=8. Expect 2 launches: the second one ≥10 ticks after the first, and one `drop_lost` pulse.
- Full pool: fill all 16 slots, issue a request. Expect `full`=1, state PEND, no `start`. Then `slot_done[5]`. Expect launch of slot 5 exactly 2 cycles after `slot_done`.
- Allocation order:
  - Retire slot 3 while slots 0–7 are busy.
  - Macro off: next launch → slot 3.
  - Macro on, pointer=8: next launch → slot 8.
  - Same setup, with slots 8–15 busy and pointer=8: launch wraps to slot 3.
- Simultaneous events: `slot_done[0]` on the same edge slot 0 would be picked. Expect slot 0 not granted that cycle, and `busy[0]`=0 afterward.
- Flush: `run`→0 mid-HOLD with 6 busy slots. Next cycle expect all outputs 0 and state IDLE. Assert `rst_n` low asynchronously mid-GAP and expect outputs 0 without a clock edge.
